line_direction_ctrl: RTL

- Parametrised successor of the line-follower steering decoder.
- Takes a configurable number of left/right reflective sensor pairs and synchronises them.
- Debounces each channel independently.
- Runs an explicit steering FSM (track / corner-hold / stop) that emits the 4-bit drive direction code to the motor controller, for forward or reverse travel.

---
 rtl/line_dir_pkg.sv | 59 +++++
 rtl/line_direction_ctrl_debounce.sv | 61 ++++++
 rtl/line_direction_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_dir_pkg.sv
// ============================================================================
// Module  : line_dir_pkg
// Purpose : Shared definitions for the line-follower steering controller.
//           - Drive direction codes {turn[1:0], severity[1:0]}
//           - Steering FSM state type
//           - Counter-width and lead-pair decode helpers
// Ports   : none (package)
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package line_dir_pkg;

  // Turn field of the direction code
  localparam logic [1:0] TURN_LEFT  = 2'b01;
  localparam logic [1:0] TURN_RIGHT = 2'b10;

  // Direction codes sent to the motor controller
  localparam logic [3:0] DIR_PROCEED      = 4'b0000;
  localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] DIR_STOP         = 4'b1111;

  // Steering FSM states. ST_SEARCH is only reachable when the search
  // feature is compiled in.
  typedef enum logic [1:0] {
    ST_TRACK       = 2'd0,
    ST_CORNER_HOLD = 2'd1,
    ST_SEARCH      = 2'd2,
    ST_STOP        = 2'd3
  } state_t;

  // Width of a counter that must be able to hold the value 'cycles'.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Code produced whenever the lead pair sees the line ({L,R} != 00).
  // The secondary pair sharpens a one-sided lead into a hard turn when it
  // sees the line on the opposite side (the track is bending across).
  function automatic logic [3:0] lead_code(input logic [1:0] lead,
                                           input logic [1:0] sec);
    logic [3:0] code;
    code = DIR_PROCEED;
    case (lead)
      2'b10:   code = (sec == 2'b01) ? DIR_HARD_LEFT  : DIR_VEER_LEFT;
      2'b01:   code = (sec == 2'b10) ? DIR_HARD_RIGHT : DIR_VEER_RIGHT;
      default: code = DIR_PROCEED;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_direction_ctrl_debounce.sv
// ============================================================================
// Module  : sensor_debounce
// Purpose : One reflective-sensor channel: two-flop synchroniser followed by
//           a hold-time debouncer. A new level is accepted only after it has
//           been seen for DEBOUNCE_CYCLES consecutive cycles; any cycle that
//           matches the accepted level restarts the count.
// Ports   : clk     in  system clock
//           rst_n   in  asynchronous active-low reset
//           raw_n   in  raw sensor, active-low (0 = line seen)
//           stable  out debounced level, active-high (1 = line seen)
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module sensor_debounce
  import line_dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic stable
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          on;
  logic [CW-1:0] cnt_q;

  // Synchroniser resets to the idle (no line) level so that the first
  // sampled value after reset agrees with stable = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_n};
    end
  end

  assign on = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else if (on == stable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable <= on;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_direction_ctrl.sv
// ============================================================================
// Module  : line_direction_ctrl
// Purpose : Line-follower steering controller. Synchronises and debounces
//           SENSOR_PAIRS left/right reflective sensor pairs, selects the
//           lead and secondary pairs for the current travel direction and
//           runs a TRACK / CORNER_HOLD / STOP steering FSM that produces the
//           4-bit drive direction code.
//           Optional feature macro: LINE_DIR_SEARCH_EN
//             When defined, a corner timeout enters a timed SEARCH state that
//             turns hard toward the last side the robot turned to.
// Ports   : clk        in  system clock
//           rst_n      in  asynchronous active-low reset
//           sens_l_n   in  [SENSOR_PAIRS] raw left sensors, active-low
//           sens_r_n   in  [SENSOR_PAIRS] raw right sensors, active-low
//           direction  in  1 = forward, 0 = reverse
//           dir        out [4] direction code {turn, severity}
//           dir_chg    out one-cycle pulse when dir changes
//           line_lost  out high while no debounced channel sees the line
//           stable_l   out [SENSOR_PAIRS] debounced left, active-high
//           stable_r   out [SENSOR_PAIRS] debounced right, active-high
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module line_direction_ctrl
  import line_dir_pkg::*;
#(
  parameter int SENSOR_PAIRS    = 3,
  parameter int DEBOUNCE_CYCLES = 12_500_000,
  parameter int CORNER_CYCLES   = 50_000_000,
  parameter int SEARCH_CYCLES   = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SENSOR_PAIRS-1:0] sens_l_n,
  input  logic [SENSOR_PAIRS-1:0] sens_r_n,
  input  logic                    direction,
  output logic [3:0]              dir,
  output logic                    dir_chg,
  output logic                    line_lost,
  output logic [SENSOR_PAIRS-1:0] stable_l,
  output logic [SENSOR_PAIRS-1:0] stable_r
);

  localparam int             CCW         = cnt_width(CORNER_CYCLES);
  localparam logic [CCW-1:0] CORNER_LAST = CCW'(CORNER_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Per-channel synchronise + debounce
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < SENSOR_PAIRS; i++) begin : g_pair
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_l (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_n  (sens_l_n[i]),
      .stable (stable_l[i])
    );

    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_r (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_n  (sens_r_n[i]),
      .stable (stable_r[i])
    );
  end

  // --------------------------------------------------------------------------
  // Lead / secondary pair selection, packed as {L,R} in the robot's frame.
  // Travelling in reverse the robot's left is the sensor bar's right, so the
  // channels are swapped as well as the pair order.
  // --------------------------------------------------------------------------
  logic [1:0] lead;
  logic [1:0] sec;

  always_comb begin
    lead = 2'b00;
    sec  = 2'b00;
    if (direction) begin
      lead = {stable_l[SENSOR_PAIRS-1], stable_r[SENSOR_PAIRS-1]};
      sec  = {stable_l[SENSOR_PAIRS-2], stable_r[SENSOR_PAIRS-2]};
    end else begin
      lead = {stable_r[0], stable_l[0]};
      sec  = {stable_r[1], stable_l[1]};
    end
  end

  // A change of travel direction re-seats the FSM in TRACK so the new lead
  // pair is evaluated from scratch.
  logic direction_q;
  logic dir_toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      direction_q <= 1'b1;
    end else begin
      direction_q <= direction;
    end
  end

  assign dir_toggle = (direction != direction_q);

  // --------------------------------------------------------------------------
  // FSM state and corner timer
  // --------------------------------------------------------------------------
  state_t         state;
  state_t         state_next;
  logic [3:0]     dir_next;
  logic [CCW-1:0] corner_cnt;
  logic           corner_done;

  assign corner_done = (corner_cnt == CORNER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  // The timer only runs while the FSM stays in CORNER_HOLD, so entering the
  // state (or being pulled out by a direction toggle) always restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_cnt <= '0;
    end else if ((state == ST_CORNER_HOLD) && (state_next == ST_CORNER_HOLD)) begin
      corner_cnt <= corner_cnt + CCW'(1);
    end else begin
      corner_cnt <= '0;
    end
  end

`ifdef LINE_DIR_SEARCH_EN
  localparam int             SCW         = cnt_width(SEARCH_CYCLES);
  localparam logic [SCW-1:0] SEARCH_LAST = SCW'(SEARCH_CYCLES - 1);

  logic [SCW-1:0] search_cnt;
  logic           search_done;
  logic           side_right;
  logic [3:0]     search_code;

  assign search_done = (search_cnt == SEARCH_LAST);
  assign search_code = side_right ? DIR_HARD_RIGHT : DIR_HARD_LEFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      search_cnt <= '0;
    end else if ((state == ST_SEARCH) && (state_next == ST_SEARCH)) begin
      search_cnt <= search_cnt + SCW'(1);
    end else begin
      search_cnt <= '0;
    end
  end

  // Remember the side of the most recent turning code. PROCEED and STOP
  // carry turn fields 00 / 11 and leave the memory untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_right <= 1'b0;
    end else if (dir_next[3:2] == TURN_RIGHT) begin
      side_right <= 1'b1;
    end else if (dir_next[3:2] == TURN_LEFT) begin
      side_right <= 1'b0;
    end
  end
`else
  logic unused_search_cfg;
  assign unused_search_cfg = (SEARCH_CYCLES > 0);
`endif

  // --------------------------------------------------------------------------
  // Next-state / next-direction logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    dir_next   = dir;

    if (dir_toggle) begin
      // Hold the current code for one cycle; TRACK re-evaluates next cycle
      // with the newly selected lead pair.
      state_next = ST_TRACK;
    end else if (lead != 2'b00) begin
      // A visible lead pair always wins, whatever the current state.
      state_next = ST_TRACK;
      dir_next   = lead_code(lead, sec);
    end else begin
      case (state)
        ST_TRACK: begin
          if (sec == 2'b10) begin
            dir_next = DIR_NINETY_LEFT;
          end else if (sec == 2'b01) begin
            dir_next = DIR_NINETY_RIGHT;
          end else begin
            state_next = ST_CORNER_HOLD;
            dir_next   = DIR_PROCEED;
          end
        end

        ST_CORNER_HOLD: begin
          dir_next = DIR_PROCEED;
          if (sec == 2'b10) begin
            state_next = ST_TRACK;
            dir_next   = DIR_NINETY_LEFT;
          end else if (sec == 2'b01) begin
            state_next = ST_TRACK;
            dir_next   = DIR_NINETY_RIGHT;
          end else if (corner_done) begin
`ifdef LINE_DIR_SEARCH_EN
            state_next = ST_SEARCH;
            dir_next   = search_code;
`else
            state_next = ST_STOP;
            dir_next   = DIR_STOP;
`endif
          end
        end

`ifdef LINE_DIR_SEARCH_EN
        ST_SEARCH: begin
          dir_next = search_code;
          if (search_done) begin
            state_next = ST_STOP;
            dir_next   = DIR_STOP;
          end
        end
`endif

        ST_STOP: begin
          dir_next = DIR_STOP;
        end

        default: begin
          state_next = ST_STOP;
          dir_next   = DIR_STOP;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir       <= DIR_STOP;
      dir_chg   <= 1'b0;
      line_lost <= 1'b1;
    end else begin
      dir       <= dir_next;
      dir_chg   <= (dir_next != dir);
      line_lost <= ~((|stable_l) | (|stable_r));
    end
  end

endmodule

`default_nettype wire
